dmem_ctrl: RTL and testbench

CPU-side controller for the four byte-wide data-memory banks (bank i holds byte lane i of each 32-bit word). Accepts byte/half/word load and store requests over a valid/ready handshake, drives the bank strobes, and returns aligned, sign- or zero-extended load data on a response channel with backpressure. Misaligned requests are rejected with an error response and never reach the banks.

---
 rtl/dmem_pkg.sv | 55 +++++
 rtl/dmem_load_fmt.sv | 35 +++
 rtl/dmem_ctrl.sv | 138 +++++++++++++
 tb/tb_dmem_ctrl.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory controller: access size
// encoding, the response FSM states, the registered response context and
// the alignment / lane-mask rules used when a request is accepted.
package dmem_pkg;

  localparam int NUM_LANES = 4;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_BAD  = 2'b11
  } size_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } state_e;

  // Everything the response channel needs to remember about the request
  // that was accepted on the previous edge.
  typedef struct packed {
    logic       we;
    logic [1:0] size;
    logic       is_unsigned;
    logic [1:0] offset;
    logic       err;
  } rsp_ctx_t;

  // A half needs an even address, a word needs a word-aligned address and
  // the reserved size code is always rejected.
  function automatic logic is_misaligned(logic [1:0] size, logic [1:0] offset);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = offset[0];
      SZ_WORD: bad = |offset;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Byte lanes touched by an aligned access.
  function automatic logic [NUM_LANES-1:0] lane_mask(logic [1:0] size, logic [1:0] offset);
    logic [NUM_LANES-1:0] mask;
    case (size)
      SZ_BYTE: mask = 4'b0001 << offset;
      SZ_HALF: mask = offset[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: mask = 4'b1111;
      default: mask = 4'b0000;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/dmem_load_fmt.sv
// Load formatter: picks the addressed lanes out of the raw bank word,
// moves them down to bit 0 and sign- or zero-extends them to 32 bits.
module dmem_load_fmt
  import dmem_pkg::*;
(
  input  logic [31:0] bank_rdata,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] load_data
);

  logic [31:0] shifted;
  logic        byte_sign;
  logic        half_sign;

  // Bring the addressed byte lane down to bit 0 (offset counts bytes).
  always_comb begin
    shifted   = bank_rdata >> {offset, 3'b000};
    byte_sign = ~is_unsigned & shifted[7];
    half_sign = ~is_unsigned & shifted[15];
  end

  // Extend the selected field according to the access size.
  always_comb begin
    load_data = 32'h0;
    case (size)
      SZ_BYTE: load_data = {{24{byte_sign}}, shifted[7:0]};
      SZ_HALF: load_data = {{16{half_sign}}, shifted[15:0]};
      SZ_WORD: load_data = bank_rdata;
      default: load_data = 32'h0;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// CPU-side controller for four byte-wide data banks. Requests are accepted
// over valid/ready, bank strobes are driven combinationally in the
// acceptance cycle, and one response per request comes back the next cycle.
// A stalled response blocks new acceptances, so no bank read is issued while
// it waits and the banks keep bank_rdata stable without a local buffer.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int ADDR_W  = 17,
  parameter int BANK_AW = ADDR_W - 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_we,
  input  logic [1:0]         req_size,
  input  logic               req_unsigned,
  input  logic [ADDR_W-1:0]  req_addr,
  input  logic [31:0]        req_wdata,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [31:0]        rsp_rdata,
  output logic               rsp_err,
  output logic [BANK_AW-1:0] bank_addr,
  output logic [3:0]         bank_re,
  output logic [3:0]         bank_we,
  output logic [31:0]        bank_wdata,
  input  logic [31:0]        bank_rdata
);

  state_e               state;
  state_e               state_nxt;
  rsp_ctx_t             ctx;
  logic                 accept;
  logic [1:0]           req_offset;
  logic                 req_err;
  logic [NUM_LANES-1:0] req_mask;
  logic [31:0]          fmt_data;

  assign req_offset = req_addr[1:0];
  assign bank_addr  = req_addr[ADDR_W-1:2];

  // Handshake: ready whenever the response slot is free or being drained,
  // never while reset is asserted.
  always_comb begin
    req_ready  = ~rst & ((state == ST_IDLE) | rsp_ready);
    accept     = req_valid & req_ready;
    req_err    = is_misaligned(req_size, req_offset);
    req_mask   = lane_mask(req_size, req_offset);
  end

  // Bank strobes only for accepted, aligned requests; misaligned ones never
  // reach the banks.
  always_comb begin
    bank_re = 4'b0000;
    bank_we = 4'b0000;
    if (accept && !req_err) begin
      if (req_we) begin
        bank_we = req_mask;
      end else begin
        bank_re = req_mask;
      end
    end
  end

  // Store data is replicated across lanes so the write enables alone pick
  // the destination bytes.
  always_comb begin
    bank_wdata = req_wdata;
    case (req_size)
      SZ_BYTE: bank_wdata = {4{req_wdata[7:0]}};
      SZ_HALF: bank_wdata = {2{req_wdata[15:0]}};
      default: bank_wdata = req_wdata;
    endcase
  end

  // Response FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: an acceptance always leads to RESP; a drained response with
  // nothing new behind it returns to IDLE; a stalled response holds.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready && !accept) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Capture the request context on acceptance; it stays frozen while the
  // response is stalled because no acceptance can happen then.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctx <= '0;
    end else if (accept) begin
      ctx.we          <= req_we;
      ctx.size        <= req_size;
      ctx.is_unsigned <= req_unsigned;
      ctx.offset      <= req_offset;
      ctx.err         <= req_err;
    end
  end

  dmem_load_fmt u_load_fmt (
    .bank_rdata  (bank_rdata),
    .offset      (ctx.offset),
    .size        (ctx.size),
    .is_unsigned (ctx.is_unsigned),
    .load_data   (fmt_data)
  );

  // Response outputs: data only for successful loads, zero otherwise.
  always_comb begin
    rsp_valid = (state == ST_RESP);
    rsp_err   = rsp_valid & ctx.err;
    rsp_rdata = 32'h0;
    if (rsp_valid && !ctx.we && !ctx.err) begin
      rsp_rdata = fmt_data;
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Testbench for dmem_ctrl: a byte-array reference model predicts every
// response and strobe, a small bank model plays the four memories.
module tb_dmem_ctrl;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [16:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [14:0] bank_addr;
  logic [3:0]  bank_re;
  logic [3:0]  bank_we;
  logic [31:0] bank_wdata;
  logic [31:0] bank_rdata;

  int total;
  int bad;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t     rsp_q[$];
  bit [7:0] shadow [0:131071];
  bit [31:0] bank_mem [0:32767];
  bit        pre_en;
  bit [14:0] pre_word;
  bit [31:0] pre_data;

  dmem_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .bank_addr    (bank_addr),
    .bank_re      (bank_re),
    .bank_we      (bank_we),
    .bank_wdata   (bank_wdata),
    .bank_rdata   (bank_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Four synchronous byte banks: write on we, registered read on re,
  // read data held otherwise. pre_en lets the bench preload a word.
  initial bank_rdata = 32'h0;
  always @(posedge clk) begin
    if (pre_en) bank_mem[pre_word] <= pre_data;
    for (int l = 0; l < 4; l++) begin
      if (bank_we[l]) bank_mem[bank_addr][8*l +: 8] <= bank_wdata[8*l +: 8];
      if (bank_re[l]) bank_rdata[8*l +: 8] <= bank_mem[bank_addr][8*l +: 8];
    end
  end

  function automatic int nbytes(bit [1:0] sz);
    case (sz)
      2'd0: return 1;
      2'd1: return 2;
      2'd2: return 4;
      default: return 0;
    endcase
  endfunction

  function automatic bit aligned(bit [1:0] sz, bit [16:0] addr);
    if (sz == 2'd3) return 1'b0;
    return (int'(addr) % nbytes(sz)) == 0;
  endfunction

  function automatic bit [3:0] exp_mask(bit [1:0] sz, bit [16:0] addr);
    bit [3:0] m;
    m = 4'b0;
    for (int i = 0; i < nbytes(sz); i++) m[(int'(addr) % 4) + i] = 1'b1;
    return m;
  endfunction

  function automatic bit [31:0] exp_wdata(bit [1:0] sz, bit [31:0] wd);
    case (sz)
      2'd0: return {4{wd[7:0]}};
      2'd1: return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  // Reference access on the byte array: little-endian bytes, then extend.
  function automatic exp_t model_access(bit we, bit [1:0] sz, bit uns, bit [16:0] addr, bit [31:0] wd);
    exp_t r;
    int n;
    bit [31:0] v;
    r.data = 32'h0;
    r.err  = 1'b0;
    n = nbytes(sz);
    if (!aligned(sz, addr)) begin
      r.err = 1'b1;
      return r;
    end
    if (we) begin
      for (int i = 0; i < n; i++) shadow[int'(addr) + i] = wd[8*i +: 8];
    end else begin
      v = 32'h0;
      for (int i = 0; i < n; i++) v[8*i +: 8] = shadow[int'(addr) + i];
      if (!uns && n < 4 && v[8*n-1]) begin
        for (int b = 8*n; b < 32; b++) v[b] = 1'b1;
      end
      r.data = v;
    end
    return r;
  endfunction

  function automatic bit model_ready();
    return !rst && (rsp_q.size() == 0 || rsp_ready);
  endfunction

  function automatic exp_t model_front();
    exp_t r;
    r.data = 32'h0;
    r.err  = 1'b0;
    if (rsp_q.size() > 0) r = rsp_q[0];
    return r;
  endfunction

  // Advance one clock edge and update the reference model with what the
  // handshake rules say happened on it.
  task automatic tick();
    bit acc, r_rst, r_rdy, we, uns;
    bit [1:0] sz;
    bit [16:0] a;
    bit [31:0] wd;
    acc = req_valid && model_ready();
    r_rst = rst; r_rdy = rsp_ready;
    we = req_we; sz = req_size; uns = req_unsigned; a = req_addr; wd = req_wdata;
    @(posedge clk);
    #1;
    if (r_rst) begin
      rsp_q.delete();
    end else begin
      if (rsp_q.size() > 0 && r_rdy) void'(rsp_q.pop_front());
      if (acc) rsp_q.push_back(model_access(we, sz, uns, a, wd));
    end
  endtask

  task automatic drive(bit v, bit we, bit [1:0] sz, bit uns, bit [16:0] a, bit [31:0] wd, bit rr);
    req_valid = v; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = a; req_wdata = wd; rsp_ready = rr;
  endtask

  task automatic preload(bit [14:0] w, bit [31:0] d);
    pre_en = 1'b1; pre_word = w; pre_data = d;
    for (int i = 0; i < 4; i++) shadow[{w, 2'b00} + i] = d[8*i +: 8];
    tick();
    pre_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1, 0, 2'd2, 0, 17'h10, 0, 1);
    @(negedge clk);
    total++; if (req_ready !== 1'b0) begin bad++; $display("[TB] FAIL reset_ready: got %b want 0", req_ready); end
    total++; if (bank_re !== 4'b0 || bank_we !== 4'b0) begin bad++; $display("[TB] FAIL reset_strobes: got re=%b we=%b want 0", bank_re, bank_we); end
    tick();
    tick();
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    total++; if (req_ready !== 1'b1) begin bad++; $display("[TB] FAIL post_reset_ready: got %b want 1", req_ready); end
    total++; if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin bad++; $display("[TB] FAIL post_reset_rsp: got v=%b e=%b d=%h want 0", rsp_valid, rsp_err, rsp_rdata); end
    tick();
    for (int w = 0; w < 16; w++) if (w != 4) preload(w[14:0], $urandom);
    preload(15'd4, 32'h80FF7F01);
  endtask

  task automatic test_load_word();
    drive(1, 0, 2'd2, 0, 17'h10, 0, 1);
    @(negedge clk);
    total++; if (bank_re !== 4'b1111 || bank_we !== 4'b0) begin bad++; $display("[TB] FAIL lw_strobes: got re=%b we=%b want 1111/0000", bank_re, bank_we); end
    total++; if (bank_addr !== 15'd4) begin bad++; $display("[TB] FAIL lw_addr: got %0d want 4", bank_addr); end
    tick();
    drive(0, 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    total++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h80FF7F01) begin bad++; $display("[TB] FAIL lw_rsp: got v=%b e=%b d=%h want 1/0/80ff7f01", rsp_valid, rsp_err, rsp_rdata); end
    tick();
  endtask

  task automatic test_subword();
    bit [16:0] a [4]  = '{17'h13, 17'h13, 17'h12, 17'h10};
    bit [1:0]  sz [4] = '{2'd0, 2'd0, 2'd1, 2'd1};
    bit        u [4]  = '{1'b0, 1'b1, 1'b0, 1'b1};
    bit [31:0] e [4]  = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h00007F01};
    for (int i = 0; i < 5; i++) begin
      if (i < 4) drive(1, 0, sz[i], u[i], a[i], 0, 1);
      else drive(0, 0, 0, 0, 0, 0, 1);
      @(negedge clk);
      if (i > 0) begin
        total++; if (rsp_valid !== 1'b1 || rsp_rdata !== e[i-1]) begin bad++; $display("[TB] FAIL subword_%0d: got v=%b d=%h want 1/%h", i-1, rsp_valid, rsp_rdata, e[i-1]); end
      end
      tick();
    end
  endtask

  task automatic test_store_then_load();
    drive(1, 1, 2'd0, 0, 17'h13, 32'h000000AB, 1);
    @(negedge clk);
    total++; if (bank_we !== 4'b1000 || bank_re !== 4'b0) begin bad++; $display("[TB] FAIL sb_strobes: got we=%b re=%b want 1000/0000", bank_we, bank_re); end
    total++; if (bank_wdata !== 32'hABABABAB) begin bad++; $display("[TB] FAIL sb_wdata: got %h want ababab ab", bank_wdata); end
    tick();
    drive(1, 0, 2'd2, 0, 17'h10, 0, 1);
    @(negedge clk);
    total++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin bad++; $display("[TB] FAIL sb_rsp: got v=%b e=%b d=%h want 1/0/0", rsp_valid, rsp_err, rsp_rdata); end
    total++; if (bank_re !== 4'b1111) begin bad++; $display("[TB] FAIL sb_reload_re: got %b want 1111", bank_re); end
    tick();
    drive(0, 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    total++; if (rsp_rdata !== 32'hABFF7F01) begin bad++; $display("[TB] FAIL sb_readback: got %h want abff7f01", rsp_rdata); end
    tick();
  endtask

  task automatic test_misaligned();
    drive(1, 0, 2'd2, 0, 17'h02, 0, 1);
    @(negedge clk);
    total++; if (bank_re !== 4'b0 || bank_we !== 4'b0) begin bad++; $display("[TB] FAIL mis_word_strobes: got re=%b we=%b want 0", bank_re, bank_we); end
    tick();
    drive(1, 1, 2'd1, 0, 17'h01, 32'h1234, 1);
    @(negedge clk);
    total++; if (bank_re !== 4'b0 || bank_we !== 4'b0) begin bad++; $display("[TB] FAIL mis_half_strobes: got re=%b we=%b want 0", bank_re, bank_we); end
    total++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0) begin bad++; $display("[TB] FAIL mis_word_rsp: got v=%b e=%b d=%h want 1/1/0", rsp_valid, rsp_err, rsp_rdata); end
    tick();
    drive(0, 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    total++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0) begin bad++; $display("[TB] FAIL mis_half_rsp: got v=%b e=%b d=%h want 1/1/0", rsp_valid, rsp_err, rsp_rdata); end
    tick();
  endtask

  task automatic test_backpressure();
    drive(1, 0, 2'd2, 0, 17'h10, 0, 1);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 2'd0, 0, 17'h12, 0, 0);
      @(negedge clk);
      total++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hABFF7F01) begin bad++; $display("[TB] FAIL bp_hold_%0d: got v=%b d=%h want 1/abff7f01", i, rsp_valid, rsp_rdata); end
      total++; if (req_ready !== 1'b0 || bank_re !== 4'b0) begin bad++; $display("[TB] FAIL bp_block_%0d: got rdy=%b re=%b want 0/0000", i, req_ready, bank_re); end
      tick();
    end
    drive(1, 0, 2'd0, 0, 17'h12, 0, 1);
    @(negedge clk);
    total++; if (req_ready !== 1'b1 || bank_re !== 4'b0100) begin bad++; $display("[TB] FAIL bp_release: got rdy=%b re=%b want 1/0100", req_ready, bank_re); end
    tick();
    drive(0, 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    total++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hFFFFFFFF) begin bad++; $display("[TB] FAIL bp_next: got v=%b d=%h want 1/ffffffff", rsp_valid, rsp_rdata); end
    tick();
  endtask

  task automatic test_reset_mid();
    drive(1, 1, 2'd2, 0, 17'h20, 32'h12345678, 1);
    tick();
    rst = 1'b1;
    drive(1, 0, 2'd2, 0, 17'h20, 0, 0);
    @(negedge clk);
    total++; if (req_ready !== 1'b0 || bank_re !== 4'b0 || bank_we !== 4'b0) begin bad++; $display("[TB] FAIL rmid_block: got rdy=%b re=%b we=%b want 0", req_ready, bank_re, bank_we); end
    tick();
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    total++; if (rsp_valid !== 1'b0 || bank_re !== 4'b0 || bank_we !== 4'b0) begin bad++; $display("[TB] FAIL rmid_drop: got v=%b re=%b we=%b want 0", rsp_valid, bank_re, bank_we); end
    drive(1, 0, 2'd2, 0, 17'h20, 0, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    total++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h12345678) begin bad++; $display("[TB] FAIL rmid_persist: got v=%b d=%h want 1/12345678", rsp_valid, rsp_rdata); end
    tick();
  endtask

  task automatic test_back_to_back();
    exp_t f;
    bit acc, ok;
    bit [3:0] m, ere, ewe;
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 79) == 0);
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 1),
            $urandom_range(0, 63), $urandom, $urandom_range(0, 3) != 0);
      @(negedge clk);
      acc = req_valid && model_ready();
      ok  = aligned(req_size, req_addr);
      m   = exp_mask(req_size, req_addr);
      ere = (acc && ok && !req_we) ? m : 4'b0;
      ewe = (acc && ok && req_we) ? m : 4'b0;
      f   = model_front();
      total++; if (req_ready !== model_ready()) begin bad++; $display("[TB] FAIL rnd_ready c%0d: got %b want %b", c, req_ready, model_ready()); end
      total++; if (bank_re !== ere || bank_we !== ewe) begin bad++; $display("[TB] FAIL rnd_strobes c%0d: got re=%b we=%b want %b/%b", c, bank_re, bank_we, ere, ewe); end
      if ((ere | ewe) != 4'b0) begin
        total++; if (bank_addr !== req_addr[16:2]) begin bad++; $display("[TB] FAIL rnd_addr c%0d: got %h want %h", c, bank_addr, req_addr[16:2]); end
      end
      if (ewe != 4'b0) begin
        total++; if (bank_wdata !== exp_wdata(req_size, req_wdata)) begin bad++; $display("[TB] FAIL rnd_wdata c%0d: got %h want %h", c, bank_wdata, exp_wdata(req_size, req_wdata)); end
      end
      total++; if (rsp_valid !== (rsp_q.size() > 0)) begin bad++; $display("[TB] FAIL rnd_valid c%0d: got %b want %b", c, rsp_valid, rsp_q.size() > 0); end
      total++; if (rsp_err !== f.err || rsp_rdata !== f.data) begin bad++; $display("[TB] FAIL rnd_rsp c%0d: got e=%b d=%h want %b/%h", c, rsp_err, rsp_rdata, f.err, f.data); end
      tick();
    end
    rst = 1'b0;
  endtask

  initial begin
    total = 0;
    bad = 0;
    pre_en = 1'b0;
    pre_word = '0;
    pre_data = '0;
    test_reset();
    test_load_word();
    test_subword();
    test_store_then_load();
    test_misaligned();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
